seq_multiplier: RTL and testbench



---
 rtl/seq_multiplier_if.sv | 49 ++++
 rtl/seq_multiplier.sv | 142 ++++++++++++++
 tb/tb_seq_multiplier.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_multiplier_if.sv
// seq_multiplier_if
//    Request/response bundle between the pipeline control and the iterative
//    multiplier.
//
//    start     : request a multiply (taken only while the unit is idle)
//    is_signed : 1 = two's-complement operands, 0 = unsigned
//    op_a      : multiplicand (ReadData1)
//    op_b      : multiplier (ReadData2)
//    busy      : operation in flight; pipeline control stalls on this
//    done      : one-cycle pulse, product valid from this cycle on
//    prod_lo   : low half of the product (MUL)
//    prod_hi   : high half of the product (SMULH/UMULH)
//
//    master : the requester (pipeline control / testbench)
//    slave  : the multiplier
interface seq_multiplier_if #(
   parameter int WIDTH = 64
);
   logic             start;
   logic             is_signed;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] prod_lo;
   logic [WIDTH-1:0] prod_hi;

   modport master (
      output start,
      output is_signed,
      output op_a,
      output op_b,
      input  busy,
      input  done,
      input  prod_lo,
      input  prod_hi
   );

   modport slave (
      input  start,
      input  is_signed,
      input  op_a,
      input  op_b,
      output busy,
      output done,
      output prod_lo,
      output prod_hi
   );
endinterface

// File: rtl/seq_multiplier.sv
// seq_multiplier
//    Iterative shift-add multiplier for MUL/SMULH/UMULH. Operands are turned
//    into magnitudes at the start edge, multiplied unsigned over WIDTH cycles,
//    and the sign is applied in one final correction cycle. Latency is fixed
//    at WIDTH+1 cycles from the start edge to the done pulse.
//
//    clk     : system clock, rising edge
//    reset_n : asynchronous, active-low reset
//    mul_if  : slave side of seq_multiplier_if (start/is_signed/op_a/op_b in,
//              busy/done/prod_lo/prod_hi out)
//
//    state | meaning
//    ------+-----------------------------------------------------------
//    IDLE  | waiting for start; product outputs hold the last result
//    RUN   | WIDTH shift-add iterations on the operand magnitudes
//    FIX   | apply sign to the accumulator, publish product, pulse done
module seq_multiplier #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset_n,
   seq_multiplier_if.slave  mul_if
);

   localparam int PW    = 2 * WIDTH;
   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } state_t;

   state_t           state_q,   state_d;
   logic [PW-1:0]    mcand_q,   mcand_d;
   logic [WIDTH-1:0] mplr_q,    mplr_d;
   logic [PW-1:0]    acc_q,     acc_d;
   logic             neg_q,     neg_d;
   logic [CNT_W-1:0] count_q,   count_d;
   logic             done_q,    done_d;
   logic [WIDTH-1:0] prod_lo_q, prod_lo_d;
   logic [WIDTH-1:0] prod_hi_q, prod_hi_d;

   logic             sign_a;
   logic             sign_b;
   logic [WIDTH-1:0] mag_a;
   logic [WIDTH-1:0] mag_b;
   logic [PW-1:0]    fix_prod;
   logic             last_iter;

   // Operand magnitudes. The most-negative value negates to itself, which
   // read as unsigned is exactly 2^(WIDTH-1), so no extra bit is needed.
   always_comb begin
      sign_a = mul_if.is_signed & mul_if.op_a[WIDTH-1];
      sign_b = mul_if.is_signed & mul_if.op_b[WIDTH-1];
      mag_a  = sign_a ? (~mul_if.op_a + WIDTH'(1)) : mul_if.op_a;
      mag_b  = sign_b ? (~mul_if.op_b + WIDTH'(1)) : mul_if.op_b;
   end

   assign last_iter = (count_q == CNT_W'(WIDTH - 1));
   assign fix_prod  = neg_q ? (~acc_q + PW'(1)) : acc_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         mcand_q   <= '0;
         mplr_q    <= '0;
         acc_q     <= '0;
         neg_q     <= 1'b0;
         count_q   <= '0;
         done_q    <= 1'b0;
         prod_lo_q <= '0;
         prod_hi_q <= '0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         mplr_q    <= mplr_d;
         acc_q     <= acc_d;
         neg_q     <= neg_d;
         count_q   <= count_d;
         done_q    <= done_d;
         prod_lo_q <= prod_lo_d;
         prod_hi_q <= prod_hi_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      mplr_d    = mplr_q;
      acc_d     = acc_q;
      neg_d     = neg_q;
      count_d   = count_q;
      done_d    = 1'b0;
      prod_lo_d = prod_lo_q;
      prod_hi_d = prod_hi_q;

      unique case (state_q)
         ST_IDLE: begin
            if (mul_if.start) begin
               mcand_d = {{WIDTH{1'b0}}, mag_a};
               mplr_d  = mag_b;
               neg_d   = sign_a ^ sign_b;
               acc_d   = '0;
               count_d = '0;
               state_d = ST_RUN;
            end
         end

         ST_RUN: begin
            if (mplr_q[0]) begin
               acc_d = acc_q + mcand_q;
            end
            mcand_d = {mcand_q[PW-2:0], 1'b0};
            mplr_d  = {1'b0, mplr_q[WIDTH-1:1]};
            count_d = count_q + CNT_W'(1);
            if (last_iter) begin
               state_d = ST_FIX;
            end
         end

         ST_FIX: begin
            prod_lo_d = fix_prod[WIDTH-1:0];
            prod_hi_d = fix_prod[PW-1:WIDTH];
            done_d    = 1'b1;
            state_d   = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // busy drops on the FIX edge together with done rising, so a start in the
   // done cycle is taken immediately.
   assign mul_if.busy    = (state_q != ST_IDLE);
   assign mul_if.done    = done_q;
   assign mul_if.prod_lo = prod_lo_q;
   assign mul_if.prod_hi = prod_hi_q;

endmodule

// File: tb/tb_seq_multiplier.sv
module tb_seq_multiplier;
   localparam int W       = 64;
   localparam int LATENCY = W + 1;

   logic clk;
   logic reset_n;

   seq_multiplier_if #(.WIDTH(W)) mif ();

   seq_multiplier #(.WIDTH(W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .mul_if  (mif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      name;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic       s;
      logic [W-1:0] exp_lo;
      logic [W-1:0] exp_hi;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: exact product from plain integer arithmetic.
   function automatic logic [127:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic s);
      logic signed [127:0] sa, sb;
      logic [127:0] ua, ub;
      if (s) begin
         sa = $signed(a);
         sb = $signed(b);
         return 128'(sa * sb);
      end
      ua = {64'b0, a};
      ub = {64'b0, b};
      return ua * ub;
   endfunction

   // Drive a request across one rising edge (E0), then scramble the operand
   // inputs so any late re-sampling shows up in the product.
   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      @(negedge clk);
      mif.start     = 1'b1;
      mif.op_a      = a;
      mif.op_b      = b;
      mif.is_signed = s;
      @(posedge clk);
      #1;
      mif.start     = 1'b0;
      mif.op_a      = ~a;
      mif.op_b      = ~b;
      mif.is_signed = ~s;
   endtask

   // Returns right after the edge that raised done (or after a timeout).
   task automatic wait_done(input string name);
      int lat;
      int busy_low;
      lat      = 0;
      busy_low = 0;
      check({name, " busy_after_E0"}, 128'(mif.busy), 128'(1));
      for (int i = 1; i <= 3 * LATENCY; i++) begin
         @(posedge clk);
         #1;
         if (mif.done) begin
            lat = i;
            break;
         end
         if (!mif.busy) busy_low++;
      end
      check({name, " latency"}, 128'(lat), 128'(LATENCY));
      check({name, " busy_low_cycles"}, 128'(busy_low), 128'(0));
      check({name, " busy_in_done"}, 128'(mif.busy), 128'(0));
   endtask

   task automatic check_prod(input string name, input logic [127:0] exp);
      check({name, " prod"}, {mif.prod_hi, mif.prod_lo}, exp);
   endtask

   task automatic check_done_drops(input string name);
      @(posedge clk);
      #1;
      check({name, " done_width"}, 128'(mif.done), 128'(0));
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      logic         rs;
      int           dones;
      int           lat;

      vecs.push_back('{"u3x5",     64'd3, 64'd5, 1'b0, 64'd15, 64'd0});
      vecs.push_back('{"umax",     64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
                       64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFE});
      vecs.push_back('{"sneg1x7",  64'hFFFF_FFFF_FFFF_FFFF, 64'd7, 1'b1,
                       64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFF});
      vecs.push_back('{"uneg1x7",  64'hFFFF_FFFF_FFFF_FFFF, 64'd7, 1'b0,
                       64'hFFFF_FFFF_FFFF_FFF9, 64'h0000_0000_0000_0006});
      vecs.push_back('{"sminxmin", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1,
                       64'd0, 64'h4000_0000_0000_0000});
      vecs.push_back('{"sminx1",   64'h8000_0000_0000_0000, 64'd1, 1'b1,
                       64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF});
      vecs.push_back('{"s3xneg2",  64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1,
                       64'hFFFF_FFFF_FFFF_FFFA, 64'hFFFF_FFFF_FFFF_FFFF});
      vecs.push_back('{"u0xmax",   64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'd0, 64'd0});

      mif.start     = 1'b0;
      mif.is_signed = 1'b0;
      mif.op_a      = '0;
      mif.op_b      = '0;
      reset_n       = 1'b0;
      #1;
      check("reset busy", 128'(mif.busy), 128'(0));
      check("reset done", 128'(mif.done), 128'(0));
      check("reset prod", {mif.prod_hi, mif.prod_lo}, 128'(0));
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      check("idle busy", 128'(mif.busy), 128'(0));

      foreach (vecs[i]) begin
         start_op(vecs[i].a, vecs[i].b, vecs[i].s);
         wait_done(vecs[i].name);
         check_prod(vecs[i].name, {vecs[i].exp_hi, vecs[i].exp_lo});
         check_done_drops(vecs[i].name);
      end

      // Start while busy is ignored; start in the done cycle is taken.
      start_op(64'd3, 64'd5, 1'b0);
      lat   = 0;
      dones = 0;
      for (int i = 1; i <= 3 * LATENCY; i++) begin
         @(posedge clk);
         #1;
         if (i == 19) begin
            mif.start     = 1'b1;
            mif.op_a      = 64'd9;
            mif.op_b      = 64'd9;
            mif.is_signed = 1'b0;
         end else if (i == 20) begin
            mif.start = 1'b0;
         end
         if (mif.done) begin
            lat = i;
            break;
         end
      end
      check("busy_start latency", 128'(lat), 128'(LATENCY));
      check_prod("busy_start", 128'd15);
      start_op(64'd9, 64'd9, 1'b0);
      check("b2b done_drops", 128'(mif.done), 128'(0));
      check("b2b hold_old", {mif.prod_hi, mif.prod_lo}, 128'd15);
      repeat (20) @(posedge clk);
      #1;
      check("b2b hold_mid", {mif.prod_hi, mif.prod_lo}, 128'd15);
      lat = 0;
      for (int i = 21; i <= 3 * LATENCY; i++) begin
         @(posedge clk);
         #1;
         if (mif.done) begin
            lat = i;
            break;
         end
      end
      check("b2b latency", 128'(lat), 128'(LATENCY));
      check_prod("b2b", 128'd81);
      check_done_drops("b2b");

      // Asynchronous reset mid-operation.
      start_op(64'd3, 64'd5, 1'b0);
      repeat (29) @(posedge clk);
      #5;
      reset_n = 1'b0;
      #1;
      check("midreset busy", 128'(mif.busy), 128'(0));
      check("midreset done", 128'(mif.done), 128'(0));
      check("midreset prod", {mif.prod_hi, mif.prod_lo}, 128'(0));
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      dones = 0;
      for (int i = 0; i < 2 * LATENCY; i++) begin
         @(posedge clk);
         #1;
         if (mif.done) dones++;
      end
      check("postreset no_done", 128'(dones), 128'(0));
      check("postreset prod", {mif.prod_hi, mif.prod_lo}, 128'(0));
      start_op(64'd2, 64'd4, 1'b0);
      wait_done("postreset 2x4");
      check_prod("postreset 2x4", 128'd8);
      check_done_drops("postreset 2x4");

      // Randomized operands against the arithmetic reference.
      for (int n = 0; n < 24; n++) begin
         case ($urandom_range(0, 4))
            0: ra = 64'h8000_0000_0000_0000;
            1: ra = 64'hFFFF_FFFF_FFFF_FFFF;
            2: ra = 64'($urandom_range(0, 255));
            default: ra = {$urandom, $urandom};
         endcase
         case ($urandom_range(0, 4))
            0: rb = 64'h8000_0000_0000_0000;
            1: rb = 64'hFFFF_FFFF_FFFF_FFFF;
            2: rb = 64'($urandom_range(0, 255));
            default: rb = {$urandom, $urandom};
         endcase
         rs = 1'($urandom_range(0, 1));
         start_op(ra, rb, rs);
         wait_done($sformatf("rand%0d", n));
         check_prod($sformatf("rand%0d a=%0h b=%0h s=%0d", n, ra, rb, rs), ref_mul(ra, rb, rs));
         if ($urandom_range(0, 1) == 1) check_done_drops($sformatf("rand%0d", n));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
